// File: rtl/reg_wb_ctrl_pkg.sv
// Shared definitions for the BeeF core write-back path: opcodes, write-back FSM states, source selects.
package reg_wb_ctrl_pkg;

    localparam int OP_W = 9;

    typedef enum logic [OP_W-1:0] {
        NOP  = 9'd0,
        INC  = 9'd1,
        DEC  = 9'd2,
        MVR  = 9'd3,
        MVL  = 9'd4,
        PUSH = 9'd5,
        POP  = 9'd6,
        IN   = 9'd7,
        OUT  = 9'd8,
        JZ   = 9'd9,
        JNZ  = 9'd10
    } op_code;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    // Ops whose register result comes back from data memory.
    function automatic logic is_mem_op(input op_code op);
        return (op == POP) || (op == MVR) || (op == MVL);
    endfunction

    function automatic logic is_alu_op(input op_code op);
        return (op == INC) || (op == DEC);
    endfunction

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Instruction, data-memory and register-file write-port signals of reg_wb_ctrl.
// Macro REG_WB_BYPASS_EN adds the fwd_valid/fwd_data forwarding outputs.
interface reg_wb_ctrl_if #(
    parameter int INSTR_W = 9,
    parameter int DATA_W  = 8
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic [DATA_W-1:0]  alu_result;
    logic               mem_req;
    logic               mem_ack;
    logic [DATA_W-1:0]  mem_rdata;
    logic               reg_we;
    logic               reg_wsrc;
    logic [DATA_W-1:0]  reg_wdata;
    logic               busy;
    logic               timeout_err;
`ifdef REG_WB_BYPASS_EN
    logic               fwd_valid;
    logic [DATA_W-1:0]  fwd_data;

    modport master (
        input  instr_valid, instr, alu_result, mem_ack, mem_rdata,
        output instr_ready, mem_req, reg_we, reg_wsrc, reg_wdata, busy, timeout_err,
               fwd_valid, fwd_data
    );

    modport slave (
        output instr_valid, instr, alu_result, mem_ack, mem_rdata,
        input  instr_ready, mem_req, reg_we, reg_wsrc, reg_wdata, busy, timeout_err,
               fwd_valid, fwd_data
    );
`else
    modport master (
        input  instr_valid, instr, alu_result, mem_ack, mem_rdata,
        output instr_ready, mem_req, reg_we, reg_wsrc, reg_wdata, busy, timeout_err
    );

    modport slave (
        output instr_valid, instr, alu_result, mem_ack, mem_rdata,
        input  instr_ready, mem_req, reg_we, reg_wsrc, reg_wdata, busy, timeout_err
    );
`endif
endinterface

// File: rtl/reg_wb_timer.sv
// Memory-access timeout counter: cleared while idle, counts waiting cycles, flags the last allowed one.
module reg_wb_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/reg_wb_ctrl.sv
// BeeF register write-back controller: decodes accepted instructions, writes ALU results directly and
// runs a req/ack read with data memory for POP/MVR/MVL. Macro REG_WB_BYPASS_EN enables forwarding outputs.
module reg_wb_ctrl
    import reg_wb_ctrl_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    reg_wb_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    wb_state_t         state_q, state_d;
    logic              we_q, we_d;
    logic              wsrc_q, wsrc_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic              expired;
    op_code            op;

    assign op     = op_code'(bus.instr);
    assign accept = bus.instr_valid && bus.instr_ready;

    reg_wb_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .enable  ((state_q == WAIT_MEM) && !bus.mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Source select and data hold their last values between writes; only we pulses.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        wsrc_d  = wsrc_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_alu_op(op)) begin
                        we_d    = 1'b1;
                        wsrc_d  = WB_SRC_ALU;
                        wdata_d = bus.alu_result;
                    end else if (is_mem_op(op)) begin
                        state_d = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_ack) begin
                    we_d    = 1'b1;
                    wsrc_d  = WB_SRC_MEM;
                    wdata_d = bus.mem_rdata;
                    state_d = IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            wsrc_q  <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            wsrc_q  <= wsrc_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE) && !reset;
    assign bus.mem_req     = (state_q == WAIT_MEM);
    assign bus.busy        = (state_q == WAIT_MEM);
    assign bus.reg_we      = we_q;
    assign bus.reg_wsrc    = wsrc_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.timeout_err = err_q;

`ifdef REG_WB_BYPASS_EN
    assign bus.fwd_valid = !reset && we_d;
    assign bus.fwd_data  = reset ? '0 : wdata_d;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed-vector bench for reg_wb_ctrl: ALU writes, memory reads with ack/timeout, and reset mid-access.
module tb_reg_wb_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    reg_wb_ctrl_if #(.INSTR_W(9), .DATA_W(8)) bus ();

    reg_wb_ctrl #(
        .INSTR_W (9),
        .DATA_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a memory op, ack on wait cycle ack_at (0 = never), then check the write-back result.
    task automatic mem_access(input logic [8:0] op, input int ack_at, input logic [7:0] data,
                              input int exp_req_cycles, input logic exp_we, input logic exp_err);
        int n = 0;
        bus.instr       = op;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (!bus.mem_req) break;
            n++;
            check_eq("ready_in_wait", bus.instr_ready, 1'b0);
            check_eq("we_in_wait", bus.reg_we, 1'b0);
            check_eq("busy_in_wait", bus.busy, 1'b1);
            if (cyc == ack_at) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = data;
            end
            tick();
            bus.mem_ack = 1'b0;
        end
        check_eq("req_cycles", n, exp_req_cycles);
        check_eq("we_after_mem", bus.reg_we, exp_we);
        check_eq("err_after_mem", bus.timeout_err, exp_err);
        check_eq("busy_after_mem", bus.busy, 1'b0);
        if (exp_we) begin
            check_eq("wsrc_mem", bus.reg_wsrc, 1'b1);
            check_eq("wdata_mem", bus.reg_wdata, data);
        end
        tick();
        check_eq("we_single_pulse", bus.reg_we, 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.alu_result  = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        tick();
        tick();
        check_eq("rst_ready", bus.instr_ready, 1'b0);
        check_eq("rst_we", bus.reg_we, 1'b0);
        check_eq("rst_wdata", bus.reg_wdata, 8'h00);
        check_eq("rst_req", bus.mem_req, 1'b0);
        check_eq("rst_err", bus.timeout_err, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("ready_after_rst", bus.instr_ready, 1'b1);

        // 1: single INC
        bus.instr       = 9'd1;
        bus.alu_result  = 8'h05;
        bus.instr_valid = 1'b1;
`ifdef REG_WB_BYPASS_EN
        #1;
        check_eq("fwd_valid", bus.fwd_valid, 1'b1);
        check_eq("fwd_data", bus.fwd_data, 8'h05);
`endif
        tick();
        bus.instr_valid = 1'b0;
        check_eq("inc_we", bus.reg_we, 1'b1);
        check_eq("inc_wsrc", bus.reg_wsrc, 1'b0);
        check_eq("inc_wdata", bus.reg_wdata, 8'h05);
        check_eq("inc_ready", bus.instr_ready, 1'b1);
        tick();
        check_eq("inc_we_drop", bus.reg_we, 1'b0);
        check_eq("inc_wdata_hold", bus.reg_wdata, 8'h05);

        // 2: INC, DEC, INC back-to-back
        bus.instr_valid = 1'b1;
        bus.instr = 9'd1; bus.alu_result = 8'h01;
        tick();
        check_eq("b2b_we0", bus.reg_we, 1'b1);
        check_eq("b2b_d0", bus.reg_wdata, 8'h01);
        bus.instr = 9'd2; bus.alu_result = 8'h02;
        tick();
        check_eq("b2b_we1", bus.reg_we, 1'b1);
        check_eq("b2b_d1", bus.reg_wdata, 8'h02);
        bus.instr = 9'd1; bus.alu_result = 8'h03;
        tick();
        bus.instr_valid = 1'b0;
        check_eq("b2b_we2", bus.reg_we, 1'b1);
        check_eq("b2b_d2", bus.reg_wdata, 8'h03);
        tick();
        check_eq("b2b_we_end", bus.reg_we, 1'b0);

        // Non-write op: accepted, nothing happens
        bus.instr = 9'd5; bus.alu_result = 8'h99; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check_eq("push_we", bus.reg_we, 1'b0);
        check_eq("push_req", bus.mem_req, 1'b0);
        check_eq("push_ready", bus.instr_ready, 1'b1);
        check_eq("push_wdata_hold", bus.reg_wdata, 8'h03);

        // 3: POP acked on third wait cycle
        mem_access(9'd6, 3, 8'hA7, 3, 1'b1, 1'b0);

        // 4: MVR with no ack times out after 15 cycles; late ack ignored
        mem_access(9'd3, 0, 8'h00, 15, 1'b0, 1'b1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
        tick();
        bus.mem_ack = 1'b0;
        check_eq("late_ack_we", bus.reg_we, 1'b0);
        check_eq("late_ack_wdata", bus.reg_wdata, 8'hA7);
        check_eq("err_sticky", bus.timeout_err, 1'b1);
        check_eq("late_ack_ready", bus.instr_ready, 1'b1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("err_cleared", bus.timeout_err, 1'b0);

        // 5: MVL acked on the last allowed cycle
        mem_access(9'd4, 15, 8'h3C, 15, 1'b1, 1'b0);

        // 6: reset during WAIT_MEM
        bus.instr = 9'd6; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check_eq("pre_rst_req", bus.mem_req, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_req", bus.mem_req, 1'b0);
        check_eq("midrst_busy", bus.busy, 1'b0);
        check_eq("midrst_we", bus.reg_we, 1'b0);
        check_eq("midrst_wdata", bus.reg_wdata, 8'h00);
        check_eq("midrst_wsrc", bus.reg_wsrc, 1'b0);
        check_eq("midrst_ready", bus.instr_ready, 1'b1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hFF;
        tick();
        bus.mem_ack = 1'b0;
        check_eq("post_rst_ack_we", bus.reg_we, 1'b0);
        check_eq("post_rst_ack_wdata", bus.reg_wdata, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
